// File: rtl/keypad_input.sv
// 4x4 keypad scanner: row drive, column synchronizer, debounce FSM
// and a one-entry command buffer toward the CPU.
module keypad_input #(
  parameter int IC_N    = 5,
  parameter int DIV_W   = 10,
  parameter int DEB_CNT = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [3:0]      row_n,
  input  logic [3:0]      col_n,
  input  logic            in_ack,
  output logic [IC_N-1:0] in_cmd,
  output logic            drop
);

  localparam int DW = $clog2(DEB_CNT + 1);
  localparam logic [DW-1:0] DEB_N = DW'(DEB_CNT);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, col_s_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]      row_q, row_d;
  logic [3:0]      key_q, key_d;
  logic [3:0]      pat_q, pat_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [IC_N-1:0] cmd_q, cmd_d;
  logic            drop_q, drop_d;

  logic            tick;
  logic            confirm;
  logic            one_low;
  logic            all_high;
  logic [3:0]      low;
  logic [1:0]      col_idx;
  logic [DW-1:0]   deb_inc;

  assign tick     = &div_q;
  assign low      = ~col_s_q;
  assign all_high = (col_s_q == 4'hF);
  assign one_low  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign deb_inc  = deb_q + 1'b1;

  assign row_n  = ~(4'b0001 << row_q);
  assign in_cmd = cmd_q;
  assign drop   = drop_q;

  always_comb begin
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) col_idx = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    key_d   = key_q;
    pat_d   = pat_q;
    deb_d   = deb_q;
    confirm = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low) begin
            key_d   = {row_q, col_idx};
            pat_d   = col_s_q;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (col_s_q == pat_q) begin
            deb_d = deb_inc;
            if (deb_inc == DEB_N) begin
              confirm = 1'b1;
              deb_d   = '0;
              state_d = RELEASE;
            end
          end else begin
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end
        end
        RELEASE: begin
          // any low column restarts the release count
          deb_d = all_high ? deb_inc : '0;
          if (all_high && deb_inc == DEB_N) begin
            deb_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    cmd_d  = cmd_q;
    drop_d = 1'b0;
    if (confirm && (cmd_q == '0 || in_ack)) begin
      cmd_d = IC_N'(5'(key_q) + 5'd1);
    end else if (confirm) begin
      drop_d = 1'b1;
    end else if (in_ack) begin
      cmd_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 4'hF;
      col_s_q <= 4'hF;
      div_q   <= '0;
      state_q <= SCAN;
      row_q   <= 2'd0;
      key_q   <= 4'd0;
      pat_q   <= 4'hF;
      deb_q   <= '0;
      cmd_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      sync1_q <= col_n;
      col_s_q <= sync1_q;
      div_q   <= div_q + 1'b1;
      state_q <= state_d;
      row_q   <= row_d;
      key_q   <= key_d;
      pat_q   <= pat_d;
      deb_q   <= deb_d;
      cmd_q   <= cmd_d;
      drop_q  <= drop_d;
    end
  end

endmodule
